// File: rtl/laser_scan_ctrl.sv
// laser_scan_ctrl: ordering/handshake sequencer for the laser-placement
// datapath. Sweeps every grid candidate over all object batches for a
// fixed number of refinement passes, emitting batch offers, compare
// strobes, swap strobes and a final done pulse. No point arithmetic here.
module laser_scan_ctrl #(
  parameter int OBJ_NUM  = 40,  // stored objects, multiple of PARALLEL, <= 64
  parameter int PARALLEL = 5,   // objects evaluated per batch
  parameter int MAX_ITER = 6,   // refinement passes, <= 8
  parameter int GRID     = 16   // candidate coordinates 0..GRID-1, <= 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic       BUSY,
  output logic       BATCH_VLD,
  input  logic       EVAL_RDY,
  output logic [5:0] MEM_ADDR,
  output logic       BATCH_LAST,
  output logic [3:0] CAND_X,
  output logic [3:0] CAND_Y,
  output logic       CAND_END,
  output logic       ITER_END,
  output logic [2:0] ITER_IDX,
  output logic       DONE
);

  localparam int NB = OBJ_NUM / PARALLEL;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [BW-1:0] BATCH_MAX = BW'(NB - 1);
  localparam logic [3:0]    CAND_MAX  = 4'(GRID - 1);
  localparam logic [2:0]    ITER_MAX  = 3'(MAX_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_COMPARE,
    S_SWAP,
    S_FINISH
  } state_t;

  state_t          state, state_next;
  logic [BW-1:0]   batch, batch_next;
  logic [3:0]      cand_x, cand_x_next;
  logic [3:0]      cand_y, cand_y_next;
  logic [2:0]      iter, iter_next;

  // State and counter registers; reset aborts any job in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state  <= S_IDLE;
      batch  <= '0;
      cand_x <= '0;
      cand_y <= '0;
      iter   <= '0;
    end else begin
      state  <= state_next;
      batch  <= batch_next;
      cand_x <= cand_x_next;
      cand_y <= cand_y_next;
      iter   <= iter_next;
    end
  end

  // Next-state and counter sequencing: batch -> candidate -> pass.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path can infer a latch.
    state_next  = state;
    batch_next  = batch;
    cand_x_next = cand_x;
    cand_y_next = cand_y;
    iter_next   = iter;

    case (state)
      S_IDLE: begin
        if (START) begin
          state_next  = S_DISPATCH;
          batch_next  = '0;
          cand_x_next = '0;
          cand_y_next = '0;
          iter_next   = '0;
        end
      end

      S_DISPATCH: begin
        // Transfer happens only when the evaluator takes the offered batch.
        if (EVAL_RDY) begin
          if (batch == BATCH_MAX) begin
            batch_next = '0;
            state_next = S_COMPARE;
          end else begin
            batch_next = batch + BW'(1);
          end
        end
      end

      S_COMPARE: begin
        if (cand_x == CAND_MAX && cand_y == CAND_MAX) begin
          state_next = S_SWAP;
        end else begin
          state_next = S_DISPATCH;
          if (cand_x == CAND_MAX) begin
            cand_x_next = '0;
            cand_y_next = cand_y + 4'd1;
          end else begin
            cand_x_next = cand_x + 4'd1;
          end
        end
      end

      S_SWAP: begin
        if (iter == ITER_MAX) begin
          state_next = S_FINISH;
        end else begin
          state_next  = S_DISPATCH;
          iter_next   = iter + 3'd1;
          cand_x_next = '0;
          cand_y_next = '0;
        end
      end

      S_FINISH: begin
        // Counters are left clean so IDLE always shows zeros.
        state_next  = S_IDLE;
        batch_next  = '0;
        cand_x_next = '0;
        cand_y_next = '0;
        iter_next   = '0;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decode registered state only; EVAL_RDY never reaches them.
  assign BUSY       = (state != S_IDLE);
  assign BATCH_VLD  = (state == S_DISPATCH);
  assign BATCH_LAST = (state == S_DISPATCH) && (batch == BATCH_MAX);
  assign MEM_ADDR   = 6'(32'(batch) * PARALLEL);
  assign CAND_X     = cand_x;
  assign CAND_Y     = cand_y;
  assign CAND_END   = (state == S_COMPARE);
  assign ITER_END   = (state == S_SWAP);
  assign ITER_IDX   = iter;
  assign DONE       = (state == S_FINISH);

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// Directed self-checking bench for laser_scan_ctrl at default parameters
// (NB=8, GRID=16, MAX_ITER=6 -> 2305 cycles per pass, DONE at cycle 13831).
module tb_laser_scan_ctrl;

  logic       CLK = 1'b0;
  logic       RST, START, EVAL_RDY;
  logic       BUSY, BATCH_VLD, BATCH_LAST, CAND_END, ITER_END, DONE;
  logic [5:0] MEM_ADDR;
  logic [3:0] CAND_X, CAND_Y;
  logic [2:0] ITER_IDX;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  localparam int PASS_CYC = 2305;
  localparam int DONE_CYC = 13831;

  laser_scan_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY),
    .BATCH_VLD(BATCH_VLD), .EVAL_RDY(EVAL_RDY), .MEM_ADDR(MEM_ADDR),
    .BATCH_LAST(BATCH_LAST), .CAND_X(CAND_X), .CAND_Y(CAND_Y),
    .CAND_END(CAND_END), .ITER_END(ITER_END), .ITER_IDX(ITER_IDX),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [22:0] out_vec();
    return {BUSY, BATCH_VLD, MEM_ADDR, BATCH_LAST, CAND_X, CAND_Y,
            CAND_END, ITER_END, ITER_IDX, DONE};
  endfunction

  int ex_x, ex_y, ex_iter, n_ce, total_ce, n_done, done_a;

  initial begin
    RST = 1'b1; START = 1'b0; EVAL_RDY = 1'b0;
    repeat (3) step();
    RST = 1'b0;

    // Idle with START low: everything stays zero.
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_outputs", 32'(out_vec()), 32'd0);
    end

    // ---- Job A: first candidate, then backpressure on the second ----
    EVAL_RDY = 1'b1;
    START = 1'b1;
    cyc = 0;
    step();
    START = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check("first_vld",  32'(BATCH_VLD), 32'd1);
      check("first_addr", 32'(MEM_ADDR), 32'(5 * (c - 1)));
      check("first_cand", 32'({CAND_X, CAND_Y}), 32'd0);
      check("first_last", 32'(BATCH_LAST), 32'(c == 8));
      step();
    end
    check("c9_cand_end", 32'({CAND_END, BATCH_VLD, CAND_X, CAND_Y}), 32'h200);
    step();
    check("c10_next_cand", 32'({BATCH_VLD, CAND_X, CAND_Y, MEM_ADDR}), {18'd0, 1'b1, 4'd1, 4'd0, 6'd0});
    step();
    step();
    check("c12_addr", 32'(MEM_ADDR), 32'd10);
    EVAL_RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", 32'({BATCH_VLD, CAND_X, CAND_Y, MEM_ADDR}), {18'd0, 1'b1, 4'd1, 4'd0, 6'd10});
      if (i == 2) EVAL_RDY = 1'b1;
    end
    step();
    check("after_stall_addr", 32'(MEM_ADDR), 32'd15);
    repeat (4) step();
    check("c20_last", 32'({BATCH_LAST, MEM_ADDR, CAND_END}), {24'd0, 1'b1, 6'd35, 1'b0});
    step();
    check("c21_cand_end_delayed", 32'({CAND_END, CAND_X, CAND_Y}), {23'd0, 1'b1, 4'd1, 4'd0});

    // Run on to pass 2, candidate (7,4): 2*2305 + 1 + 3 stall + 71*9 = 5253.
    done_a = 0;
    while (!(ITER_IDX == 3'd2 && CAND_X == 4'd7 && CAND_Y == 4'd4) && cyc < 20000) begin
      step();
      if (DONE) done_a++;
    end
    check("abort_point_cycle", 32'(cyc), 32'd5253);
    check("abort_point_vld",   32'({BATCH_VLD, MEM_ADDR}), {25'd0, 1'b1, 6'd0});
    RST = 1'b1;
    step();
    check("abort_outputs_zero", 32'(out_vec()), 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_stays_idle", 32'(out_vec()), 32'd0);
    end
    check("abort_no_done", 32'(done_a), 32'd0);

    // ---- Job B: full run with stray START pulses ----
    START = 1'b1;
    cyc = 0;
    step();
    START = 1'b0;
    check("restart_state", 32'({BATCH_VLD, ITER_IDX, CAND_X, CAND_Y, MEM_ADDR}), {14'd0, 1'b1, 3'd0, 4'd0, 4'd0, 6'd0});

    ex_x = 0; ex_y = 0; ex_iter = 0; n_ce = 0; total_ce = 0; n_done = 0;
    while (cyc < DONE_CYC + 1) begin
      step();
      START = (cyc == 5 || cyc == 900 || cyc == PASS_CYC || cyc == 3 * PASS_CYC);
      check("strobe_exclusive", 32'($onehot0({BATCH_VLD, CAND_END, ITER_END, DONE})), 32'd1);
      check("busy", 32'(BUSY), 32'(cyc <= DONE_CYC));
      if (cyc == 144) check("row_end_cand", 32'({CAND_END, CAND_X, CAND_Y}), {23'd0, 1'b1, 4'd15, 4'd0});
      if (cyc == 145) check("row_wrap_cand", 32'({CAND_X, CAND_Y}), {24'd0, 4'd0, 4'd1});
      if (CAND_END) begin
        check("cand_end_cycle", 32'(cyc), 32'(PASS_CYC * ex_iter + 9 * (n_ce + 1)));
        check("cand_end_pos", 32'({ITER_IDX, CAND_X, CAND_Y}), {21'd0, 3'(ex_iter), 4'(ex_x), 4'(ex_y)});
        if (ex_x == 15) begin ex_x = 0; ex_y++; end else ex_x++;
        n_ce++;
        total_ce++;
      end
      if (ITER_END) begin
        check("iter_end_cycle", 32'(cyc), 32'(PASS_CYC * (ex_iter + 1)));
        check("iter_end_idx", 32'(ITER_IDX), 32'(ex_iter));
        check("cand_ends_per_pass", 32'(n_ce), 32'd256);
        ex_iter++;
        n_ce = 0; ex_x = 0; ex_y = 0;
      end
      if (DONE) begin
        check("done_cycle", 32'(cyc), 32'(DONE_CYC));
        n_done++;
      end
    end
    check("done_count", 32'(n_done), 32'd1);
    check("pass_count", 32'(ex_iter), 32'd6);
    check("cand_end_total", 32'(total_ce), 32'd1536);
    check("idle_after_done", 32'(out_vec()), 32'd0);

    // New START accepted the cycle after DONE.
    START = 1'b1;
    step();
    START = 1'b0;
    check("restart_after_done", 32'({BUSY, BATCH_VLD, ITER_IDX, CAND_X, CAND_Y}), {19'd0, 1'b1, 1'b1, 3'd0, 4'd0, 4'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/laser_scan_ctrl.md
Name: laser_scan_ctrl

Overview:
- Sequencer for the laser-placement datapath: object memory, PARALLEL circle-inclusion evaluators, and the best-candidate / dirty-mask accumulator.
- After START, it sweeps every grid candidate centre (CAND_X, CAND_Y) over all object batches, for MAX_ITER alternating C1/C2 refinement passes.
- Emits batch dispatches, per-candidate compare strobes, per-pass swap strobes and a final DONE.
- Holds no object data and does no arithmetic on points; it only owns ordering and handshakes.

Parameters:
- OBJ_NUM, 40, number of stored objects; must be a multiple of PARALLEL and ≤ 64.
- PARALLEL, 5, objects evaluated per batch; NB = OBJ_NUM/PARALLEL batches per candidate (8 at defaults).
- MAX_ITER, 6, number of full-grid refinement passes.
- GRID, 16, candidate coordinates run 0..GRID-1; GRID ≤ 16.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request to begin a job; sampled only in IDLE.
- BUSY  out  1  high in every state except IDLE.
- BATCH_VLD  out  1  batch at MEM_ADDR for candidate CAND_X/CAND_Y is offered.
- EVAL_RDY  in  1  evaluator/accumulator accepts the offered batch.
- MEM_ADDR  out  6  base object index of the batch (batch*PARALLEL).
- BATCH_LAST  out  1  offered batch is batch NB-1 of the current candidate.
- CAND_X  out  4  current candidate column.
- CAND_Y  out  4  current candidate row.
- CAND_END  out  1  one-cycle compare strobe; the accumulator compares its count for CAND_X/CAND_Y.
- ITER_END  out  1  one-cycle swap strobe; the accumulator swaps its C1/C2 state.
- ITER_IDX  out  3  index of the current pass, 0..MAX_ITER-1.
- DONE  out  1  one-cycle pulse; the job is complete.

Behaviour:
- All outputs are registered or decoded directly from registered state. No combinational path from EVAL_RDY to any output.
- Reset:
  - State goes to IDLE.
  - All outputs 0.
  - Batch, candidate and pass counters go to 0.
  - Reset asserted mid-job aborts immediately, with no DONE, CAND_END or ITER_END emitted.
- States: IDLE, DISPATCH, COMPARE, SWAP, FINISH.
- IDLE:
  - START=1 clears all counters and moves to DISPATCH.
  - START=0 stays in IDLE.
  - START is ignored in every other state.
- DISPATCH:
  - BATCH_VLD=1, MEM_ADDR=batch*PARALLEL, BATCH_LAST=(batch==NB-1).
  - A transfer occurs on any cycle with BATCH_VLD && EVAL_RDY.
  - On transfer with batch==NB-1: batch←0, move to COMPARE.
  - On transfer with any other batch: batch++.
  - No transfer: hold everything. Backpressure may last any number of cycles.
- COMPARE (1 cycle):
  - CAND_END=1, with CAND_X/CAND_Y still showing the evaluated candidate.
  - If CAND_X==GRID-1 and CAND_Y==GRID-1: go to SWAP.
  - Otherwise advance raster order and return to DISPATCH: CAND_X++; when CAND_X wraps from GRID-1 to 0, CAND_Y++.
- SWAP (1 cycle):
  - ITER_END=1, with ITER_IDX showing the finished pass.
  - If ITER_IDX==MAX_ITER-1: go to FINISH.
  - Otherwise ITER_IDX++, candidate←(0,0), return to DISPATCH.
- FINISH (1 cycle): DONE=1, then go to IDLE. All counters are cleared on entry to IDLE.
- BATCH_VLD, CAND_END, ITER_END and DONE are mutually exclusive.
- Timing with EVAL_RDY held high:
  - NB+1 cycles per candidate.
  - GRID²·(NB+1)+1 cycles per pass: 2305 at defaults.
  - Cycle 0 is the one where START is sampled; DONE is high in cycle 1 + MAX_ITER·2305 = 13831 at defaults.
- A new START is accepted in the cycle after DONE (state is already IDLE).

Test Plan:
- Reset, then hold IDLE with START=0 for 10 cycles → all outputs 0, BUSY=0.
- START pulse with EVAL_RDY=1 →
  - Cycles 1..8: BATCH_VLD=1, MEM_ADDR = 0,5,…,35, CAND=(0,0).
  - Cycle 8: BATCH_LAST=1.
  - Cycle 9: CAND_END=1 with CAND=(0,0).
  - Cycle 10: CAND=(1,0), MEM_ADDR=0.
- EVAL_RDY low for 3 cycles while MEM_ADDR=10 → MEM_ADDR, CAND and BATCH_VLD held; next batch at MEM_ADDR=15 appears only after EVAL_RDY=1; CAND_END is delayed by exactly 3 cycles.
- Full run, EVAL_RDY=1 →
  - 256 CAND_END pulses per pass in raster order.
  - CAND advances (15,0)→(0,1) at the row wrap.
  - ITER_END at cycles 2305·k (k=1..6) with ITER_IDX=k-1.
  - DONE only at cycle 13831, then BUSY=0.
- START pulses during DISPATCH and during SWAP → no effect on counters or timing; DONE still at cycle 13831.
- RST asserted mid-pass (ITER_IDX=2, CAND=(7,4)) → next cycle all outputs 0, state IDLE, no DONE; a following START restarts from CAND=(0,0), ITER_IDX=0.
